// File: rtl/mips_core_pkg.sv
// Shared core types for the misprediction recovery path: active-list
// geometry, index type and the recovery FSM state encoding.
package mips_core_pkg;

   localparam int unsigned AL_DEPTH = 32;
   localparam int unsigned AL_IDX_W = $clog2(AL_DEPTH);

   typedef logic [AL_IDX_W-1:0] AlIndex;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQUASH = 2'd1,
      WALK   = 2'd2,
      DONE   = 2'd3
   } RecoveryState;

endpackage

// File: rtl/al_age_compare.sv
// Active-list age comparator: a_older is set when entry a was allocated
// before entry b, measuring age as distance from the current head.
module al_age_compare #(
   parameter int unsigned AL_IDX_W = 5
) (
   input  logic [AL_IDX_W-1:0] al_head,
   input  logic [AL_IDX_W-1:0] a,
   input  logic [AL_IDX_W-1:0] b,
   output logic                a_older
);
   import mips_core_pkg::*;

   logic [AL_IDX_W-1:0] age_a;
   logic [AL_IDX_W-1:0] age_b;

   // Ages wrap through index-width truncation, so the head is always age 0.
   always_comb begin
      age_a   = a - al_head;
      age_b   = b - al_head;
      a_older = (age_a < age_b);
   end

endmodule

// File: rtl/recovery_sequencer.sv
// Misprediction recovery sequencer: squashes the instruction queue, walks
// the active list from tail back to the kept entry restoring the map table
// and freeing tags, then rewinds the tail and signals end of flush.
// Optional feature macro: RECOVERY_STATS_EN adds saturating stat counters.
module recovery_sequencer #(
   parameter int unsigned AL_DEPTH = 32,
   parameter int unsigned AL_IDX_W = $clog2(AL_DEPTH),
   parameter int unsigned PHYS_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_req,
   input  logic [AL_IDX_W-1:0] flush_idx,
   input  logic [AL_IDX_W-1:0] al_head,
   input  logic [AL_IDX_W-1:0] al_tail,
   output logic [AL_IDX_W-1:0] al_rd_idx,
   input  logic                al_rd_uses_rw,
   input  logic [4:0]          al_rd_arch,
   input  logic [PHYS_W-1:0]   al_rd_prev_phys,
   input  logic [PHYS_W-1:0]   al_rd_new_phys,
   output logic                map_restore_en,
   output logic [4:0]          map_restore_arch,
   output logic [PHYS_W-1:0]   map_restore_phys,
   output logic                free_push_en,
   output logic [PHYS_W-1:0]   free_push_tag,
   output logic                iq_flush,
   output logic                iq_block,
   output logic                al_set_tail,
   output logic [AL_IDX_W-1:0] al_new_tail,
   output logic                end_flush,
`ifdef RECOVERY_STATS_EN
   output logic [15:0]         stat_flushes,
   output logic [15:0]         stat_squashed,
`endif
   output logic                busy
);
   import mips_core_pkg::*;

   localparam logic [AL_IDX_W-1:0] IDX_ONE = 1;

   RecoveryState        state;
   logic [AL_IDX_W-1:0] bound;
   logic [AL_IDX_W-1:0] wptr;

   logic                req_older;
   logic                nested_accept;
   logic [AL_IDX_W-1:0] eff_bound;
   logic [AL_IDX_W-1:0] wptr_dec;
   logic                walking;

   al_age_compare #(.AL_IDX_W(AL_IDX_W)) u_age (
      .al_head (al_head),
      .a       (flush_idx),
      .b       (bound),
      .a_older (req_older)
   );

   // Nested-flush acceptance and the bound used by this cycle's exit check.
   always_comb begin
      nested_accept = flush_req && req_older && (state == SQUASH || state == WALK);
      eff_bound     = nested_accept ? flush_idx : bound;
      wptr_dec      = wptr - IDX_ONE;
      walking       = (state == WALK);
   end

   // Active-list read and rollback writes, combinational from read data.
   always_comb begin
      al_rd_idx        = walking ? wptr : '0;
      map_restore_en   = walking && al_rd_uses_rw;
      map_restore_arch = map_restore_en ? al_rd_arch : '0;
      map_restore_phys = map_restore_en ? al_rd_prev_phys : '0;
      free_push_en     = map_restore_en;
      free_push_tag    = map_restore_en ? al_rd_new_phys : '0;
   end

   // Recovery FSM; control outputs are registered alongside the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bound       <= '0;
         wptr        <= '0;
         iq_flush    <= 1'b0;
         iq_block    <= 1'b0;
         busy        <= 1'b0;
         al_set_tail <= 1'b0;
         al_new_tail <= '0;
         end_flush   <= 1'b0;
      end else begin
         iq_flush    <= 1'b0;
         al_set_tail <= 1'b0;
         al_new_tail <= '0;
         end_flush   <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_req) begin
                  bound    <= flush_idx;
                  wptr     <= al_tail - IDX_ONE;
                  state    <= SQUASH;
                  iq_flush <= 1'b1;
                  iq_block <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            SQUASH: begin
               bound <= eff_bound;
               if (wptr == eff_bound) begin
                  state       <= DONE;
                  al_set_tail <= 1'b1;
                  al_new_tail <= eff_bound + IDX_ONE;
                  end_flush   <= 1'b1;
               end else begin
                  state <= WALK;
               end
            end
            WALK: begin
               bound <= eff_bound;
               wptr  <= wptr_dec;
               if (wptr_dec == eff_bound) begin
                  state       <= DONE;
                  al_set_tail <= 1'b1;
                  al_new_tail <= eff_bound + IDX_ONE;
                  end_flush   <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               iq_block <= 1'b0;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RECOVERY_STATS_EN
   // Saturating counters of accepted flushes and walked entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_flushes  <= '0;
         stat_squashed <= '0;
      end else begin
         if (state == IDLE && flush_req && stat_flushes != '1)
            stat_flushes <= stat_flushes + 16'd1;
         if (walking && stat_squashed != '1)
            stat_squashed <= stat_squashed + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed scoreboard bench for recovery_sequencer. Stats ports are
// exercised when RECOVERY_STATS_EN is defined.
module tb_recovery_sequencer;

   localparam int unsigned AW = 5;
   localparam int unsigned PW = 6;

   typedef struct packed {
      logic          iq_flush;
      logic          iq_block;
      logic          busy;
      logic          map_en;
      logic [4:0]    arch;
      logic [PW-1:0] phys;
      logic          free_en;
      logic [PW-1:0] free_tag;
      logic          set_tail;
      logic [AW-1:0] new_tail;
      logic          end_flush;
      logic [AW-1:0] rd_idx;
   } obs_t;

   logic          clk;
   logic          rst;
   logic          flush_req;
   logic [AW-1:0] flush_idx;
   logic [AW-1:0] al_head;
   logic [AW-1:0] al_tail;
   logic [AW-1:0] al_rd_idx;
   logic          al_rd_uses_rw;
   logic [4:0]    al_rd_arch;
   logic [PW-1:0] al_rd_prev_phys;
   logic [PW-1:0] al_rd_new_phys;
   logic          map_restore_en;
   logic [4:0]    map_restore_arch;
   logic [PW-1:0] map_restore_phys;
   logic          free_push_en;
   logic [PW-1:0] free_push_tag;
   logic          iq_flush;
   logic          iq_block;
   logic          al_set_tail;
   logic [AW-1:0] al_new_tail;
   logic          end_flush;
   logic          busy;
`ifdef RECOVERY_STATS_EN
   logic [15:0]   stat_flushes;
   logic [15:0]   stat_squashed;
`endif

   logic          mem_uses [32];
   logic [4:0]    mem_arch [32];
   logic [PW-1:0] mem_prev [32];
   logic [PW-1:0] mem_new  [32];

   obs_t  exp_q [$];
   string tag_q [$];
   int    n_cmp  = 0;
   int    n_fail = 0;
   int    exp_flushes  = 0;
   int    exp_squashed = 0;

   recovery_sequencer #(.AL_DEPTH(32), .PHYS_W(PW)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_req        (flush_req),
      .flush_idx        (flush_idx),
      .al_head          (al_head),
      .al_tail          (al_tail),
      .al_rd_idx        (al_rd_idx),
      .al_rd_uses_rw    (al_rd_uses_rw),
      .al_rd_arch       (al_rd_arch),
      .al_rd_prev_phys  (al_rd_prev_phys),
      .al_rd_new_phys   (al_rd_new_phys),
      .map_restore_en   (map_restore_en),
      .map_restore_arch (map_restore_arch),
      .map_restore_phys (map_restore_phys),
      .free_push_en     (free_push_en),
      .free_push_tag    (free_push_tag),
      .iq_flush         (iq_flush),
      .iq_block         (iq_block),
      .al_set_tail      (al_set_tail),
      .al_new_tail      (al_new_tail),
      .end_flush        (end_flush),
`ifdef RECOVERY_STATS_EN
      .stat_flushes     (stat_flushes),
      .stat_squashed    (stat_squashed),
`endif
      .busy             (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Active-list storage owned by the bench; read data returns combinationally.
   always_comb begin
      al_rd_uses_rw   = mem_uses[al_rd_idx];
      al_rd_arch      = mem_arch[al_rd_idx];
      al_rd_prev_phys = mem_prev[al_rd_idx];
      al_rd_new_phys  = mem_new[al_rd_idx];
   end

   function automatic obs_t exp_idle();
      obs_t o = '0;
      return o;
   endfunction

   function automatic obs_t exp_squash();
      obs_t o = '0;
      o.iq_flush = 1'b1;
      o.iq_block = 1'b1;
      o.busy     = 1'b1;
      return o;
   endfunction

   function automatic obs_t exp_walk(input int idx);
      obs_t o = '0;
      o.iq_block = 1'b1;
      o.busy     = 1'b1;
      o.rd_idx   = 5'(idx);
      if (mem_uses[idx]) begin
         o.map_en   = 1'b1;
         o.arch     = mem_arch[idx];
         o.phys     = mem_prev[idx];
         o.free_en  = 1'b1;
         o.free_tag = mem_new[idx];
      end
      return o;
   endfunction

   function automatic obs_t exp_done(input int new_tail);
      obs_t o = '0;
      o.iq_block  = 1'b1;
      o.busy      = 1'b1;
      o.set_tail  = 1'b1;
      o.new_tail  = 5'(new_tail);
      o.end_flush = 1'b1;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.iq_flush  = iq_flush;
      o.iq_block  = iq_block;
      o.busy      = busy;
      o.map_en    = map_restore_en;
      o.arch      = map_restore_arch;
      o.phys      = map_restore_phys;
      o.free_en   = free_push_en;
      o.free_tag  = free_push_tag;
      o.set_tail  = al_set_tail;
      o.new_tail  = al_new_tail;
      o.end_flush = end_flush;
      o.rd_idx    = al_rd_idx;
      return o;
   endfunction

   task automatic push(input string tag, input obs_t o);
      exp_q.push_back(o);
      tag_q.push_back(tag);
   endtask

   task automatic push_walk(input string tag, input int idx);
      push(tag, exp_walk(idx));
      exp_squashed++;
   endtask

   // Advance one clock and compare the settled outputs with the oldest expectation.
   task automatic tick();
      obs_t  got;
      obs_t  want;
      string tag;
      @(negedge clk);
      got = sample();
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required queued entry", got);
      end else begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         n_cmp++;
         assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, got, want);
         end
      end
   endtask

   task automatic start(input int idx, input int tail);
      flush_req = 1'b1;
      flush_idx = 5'(idx);
      al_tail   = 5'(tail);
      push("squash", exp_squash());
      tick();
      flush_req = 1'b0;
      exp_flushes++;
   endtask

   task automatic check_stats(input string tag);
`ifdef RECOVERY_STATS_EN
      n_cmp++;
      assert (stat_flushes === 16'(exp_flushes)) else begin
         n_fail++;
         $error("FAIL %s_flushes: observed %0d required %0d", tag, stat_flushes, exp_flushes);
      end
      n_cmp++;
      assert (stat_squashed === 16'(exp_squashed)) else begin
         n_fail++;
         $error("FAIL %s_squashed: observed %0d required %0d", tag, stat_squashed, exp_squashed);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem_uses[i] = 1'b1;
         mem_arch[i] = 5'(i + 7);
         mem_prev[i] = 6'(i + 40);
         mem_new[i]  = 6'(i * 2 + 1);
      end
      rst       = 1'b1;
      flush_req = 1'b0;
      flush_idx = '0;
      al_head   = '0;
      al_tail   = '0;

      // Reset state.
      push("reset0", exp_idle());
      tick();
      push("reset1", exp_idle());
      tick();
      rst = 1'b0;
      push("idle_after_reset", exp_idle());
      tick();

      // Basic walk: tail 5, keep 2.
      start(2, 5);
      push_walk("basic_w4", 4);
      tick();
      push_walk("basic_w3", 3);
      tick();
      push("basic_done", exp_done(3));
      tick();
      push("basic_idle", exp_idle());
      tick();

      // Nothing to squash.
      start(4, 5);
      push("none_done", exp_done(5));
      tick();
      push("none_idle", exp_idle());
      tick();

      // Wrap-around walk.
      al_head = 5'd20;
      start(29, 2);
      push_walk("wrap_w1", 1);
      tick();
      push_walk("wrap_w0", 0);
      tick();
      push_walk("wrap_w31", 31);
      tick();
      push_walk("wrap_w30", 30);
      tick();
      push("wrap_done", exp_done(30));
      tick();
      push("wrap_idle", exp_idle());
      tick();
      al_head = '0;

      // Entry without destination register.
      mem_uses[3] = 1'b0;
      start(2, 5);
      push_walk("nodest_w4", 4);
      tick();
      push_walk("nodest_w3", 3);
      tick();
      push("nodest_done", exp_done(3));
      tick();
      push("nodest_idle", exp_idle());
      tick();
      mem_uses[3] = 1'b1;

      // Nested older flush extends the walk.
      start(2, 5);
      push_walk("nest_w4", 4);
      tick();
      flush_req = 1'b1;
      flush_idx = 5'd1;
      push_walk("nest_w3", 3);
      tick();
      flush_req = 1'b0;
      push_walk("nest_w2", 2);
      tick();
      push("nest_done", exp_done(2));
      tick();
      push("nest_idle", exp_idle());
      tick();

      // Nested younger flush is ignored.
      start(2, 5);
      push_walk("ign_w4", 4);
      tick();
      flush_req = 1'b1;
      flush_idx = 5'd3;
      push_walk("ign_w3", 3);
      tick();
      flush_req = 1'b0;
      push("ign_done", exp_done(3));
      tick();
      push("ign_idle", exp_idle());
      tick();

      check_stats("stats_mid");

      // Reset during a walk aborts without end_flush.
      start(2, 5);
      push_walk("rst_w4", 4);
      tick();
      push_walk("rst_w3", 3);
      tick();
      rst          = 1'b1;
      exp_flushes  = 0;
      exp_squashed = 0;
      push("rst_idle", exp_idle());
      tick();
      rst = 1'b0;
      push("rst_idle2", exp_idle());
      tick();

      check_stats("stats_end");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
